// File: rtl/uart_pkg.sv
// uart_pkg: shared byte constants, FSM state encoding and baud divisor helper for the UART transmitter
package uart_pkg;
  localparam logic [7:0] CR_BYTE = 8'h0D;
  localparam logic [7:0] LF_BYTE = 8'h0A;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_CR    = 3'd5;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: baud counter and shift register producing one 8N1 frame per start pulse
module uart_tx_serializer import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [2:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  logic          tick;
  assign tick   = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign done_o = phase_q == S_STOP && tick;
  assign tx_o   = phase_q == S_START ? 1'b0 : phase_q == S_DATA ? sh_q[0] : 1'b1;
  always_comb begin
    phase_d = phase_q;
    cnt_d   = '0;
    sh_d    = sh_q;
    bit_d   = bit_q;
    if (phase_q == S_IDLE) begin
      if (start_i) begin
        phase_d = S_START;
        sh_d    = data_i;
        bit_d   = '0;
      end
    end else if (!tick) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      phase_d = phase_q == S_START ? S_DATA :
                phase_q == S_DATA  ? (bit_q == 3'd7 ? S_STOP : S_DATA) : S_IDLE;
      if (phase_q == S_DATA) begin
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 3'd1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      phase_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
    end
endmodule

// File: rtl/uart_line_transmitter.sv
// uart_line_transmitter: byte FIFO drained on request as back-to-back 8N1 frames, optionally closed by CR
module uart_line_transmitter import uart_pkg::*; #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DEPTH     = 32,
  parameter int APPEND_CR = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [7:0]               char_in_i,
  input  logic                     char_push_i,
  input  logic                     send_i,
  input  logic                     clear_i,
  output logic                     rs_tx_o,
  output logic                     tx_busy_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic [7:0]               tx_byte_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [2:0]  state_q, state_d;
  logic        drain_q, drain_d, cr_sent_q, cr_sent_d, overflow_q;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        push, pop, ser_start, ser_done;
  assign count_o    = wr_q - rd_q;
  assign empty_o    = count_o == '0;
  assign full_o     = count_o == (AW+1)'(DEPTH);
  assign overflow_o = overflow_q;
  assign tx_byte_o  = tx_byte_q;
  assign tx_busy_o  = drain_q | (state_q != S_IDLE);
  assign pop        = state_q == S_LOAD;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted then
  assign push       = char_push_i & ~clear_i & (~full_o | pop);
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q & ~clear_i;
    cr_sent_d = cr_sent_q;
    tx_byte_d = tx_byte_q;
    ser_start = 1'b0;
    case (state_q)
      S_IDLE:
        if (send_i && !clear_i && !drain_q && (!empty_o || APPEND_CR != 0)) begin
          state_d   = empty_o ? S_CR : S_LOAD;
          drain_d   = 1'b1;
          cr_sent_d = 1'b0;
        end
      S_LOAD: begin
        tx_byte_d = mem_q[rd_q[AW-1:0]];
        ser_start = 1'b1;
        state_d   = S_START;
      end
      S_CR: begin
        tx_byte_d = CR_BYTE;
        ser_start = 1'b1;
        cr_sent_d = 1'b1;
        state_d   = S_START;
      end
      // Remaining codes: a frame is on the line and the serializer tracks START/DATA/STOP
      default:
        if (ser_done) begin
          state_d = !drain_d ? S_IDLE : !empty_o ? S_LOAD :
                    (APPEND_CR != 0 && !cr_sent_q) ? S_CR : S_IDLE;
          drain_d = drain_d && state_d != S_IDLE;
        end
    endcase
  end
  always_ff @(posedge clk_i)
    if (push) mem_q[wr_q[AW-1:0]] <= char_in_i;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      drain_q    <= 1'b0;
      cr_sent_q  <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      wr_q       <= clear_i ? '0 : wr_q + (AW+1)'(push);
      rd_q       <= clear_i ? '0 : rd_q + (AW+1)'(pop);
      overflow_q <= ~clear_i & (overflow_q | (char_push_i & full_o & ~pop));
      state_q    <= state_d;
      drain_q    <= drain_d;
      cr_sent_q  <= cr_sent_d;
      tx_byte_q  <= tx_byte_d;
    end
  uart_tx_serializer #(.CLKS_PER_BIT(clks_per_bit(CLK_HZ, BAUD))) u_ser (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start_i  (ser_start),
    .data_i   (tx_byte_d),
    .tx_o     (rs_tx_o),
    .done_o   (ser_done)
  );
endmodule

// File: tb/tb_uart_line_transmitter.sv
// tb_uart_line_transmitter: directed checks of queueing, framing, CR append, clear and reset at 10 clocks per bit
module tb_uart_line_transmitter;
  logic       clk = 1'b0, rst_n = 1'b0, push = 1'b0, send = 1'b0, clr = 1'b0, send2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx, busy, full, empty, ovf, tx2, busy2, full2, empty2, ovf2;
  logic [5:0] cnt, cnt2;
  logic [7:0] txb, txb2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  uart_line_transmitter #(.CLK_HZ(1000), .BAUD(100), .DEPTH(32), .APPEND_CR(1)) dut (
    .clk_i(clk), .reset_ni(rst_n), .char_in_i(din), .char_push_i(push), .send_i(send),
    .clear_i(clr), .rs_tx_o(tx), .tx_busy_o(busy), .count_o(cnt), .full_o(full),
    .empty_o(empty), .overflow_o(ovf), .tx_byte_o(txb)
  );
  uart_line_transmitter #(.CLK_HZ(1000), .BAUD(100), .DEPTH(32), .APPEND_CR(0)) u_nocr (
    .clk_i(clk), .reset_ni(rst_n), .char_in_i(8'h00), .char_push_i(1'b0), .send_i(send2),
    .clear_i(1'b0), .rs_tx_o(tx2), .tx_busy_o(busy2), .count_o(cnt2), .full_o(full2),
    .empty_o(empty2), .overflow_o(ovf2), .tx_byte_o(txb2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_byte(input logic [7:0] b);
    din  = b;
    push = 1'b1;
    tk(1);
    push = 1'b0;
  endtask
  task automatic pulse_send;
    send = 1'b1;
    tk(1);
    send = 1'b0;
  endtask
  // Called on the first cycle of a start bit; returns at the middle of the stop bit (+95)
  task automatic frame(input logic [7:0] b, input bit clr_in_data);
    chk("start_edge", tx, 1'b0);
    chk("tx_byte", txb, b);
    tk(5);
    chk("start_bit", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (clr_in_data && i == 1) begin
        clr = 1'b1;
        tk(1);
        clr = 1'b0;
        chk("clear_count", cnt, 6'd0);
        tk(9);
      end else tk(10);
      chk($sformatf("data_bit%0d_of_%02h", i, b), tx, b[i]);
    end
    tk(10);
    chk("stop_bit", tx, 1'b1);
  endtask
  initial begin
    tk(2);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", cnt, 6'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_txbyte", txb, 8'h00);
    rst_n = 1'b1;
    tk(2);
    // single byte followed by CR
    push_byte(8'h41);
    chk("one_count", cnt, 6'd1);
    pulse_send;
    chk("load_cycle_idle_line", tx, 1'b1);
    chk("load_cycle_busy", busy, 1'b1);
    tk(1);
    frame(8'h41, 1'b0);
    tk(6);
    frame(8'h0D, 1'b0);
    chk("cr_stop_busy", busy, 1'b1);
    tk(5);
    chk("after_cr_busy", busy, 1'b0);
    chk("after_cr_tx", tx, 1'b1);
    tk(5);
    // push during drain joins the same drain; a mid-drain send is ignored
    push_byte(8'h41);
    push_byte(8'h42);
    pulse_send;
    tk(1);
    frame(8'h41, 1'b0);
    push_byte(8'h43);
    pulse_send;
    tk(4);
    frame(8'h42, 1'b0);
    tk(6);
    frame(8'h43, 1'b0);
    tk(6);
    frame(8'h0D, 1'b0);
    tk(5);
    chk("abc_busy_end", busy, 1'b0);
    chk("abc_empty_end", empty, 1'b1);
    // clear during the first frame's data: frame completes, nothing else, no CR
    push_byte(8'h55);
    push_byte(8'h66);
    push_byte(8'h77);
    pulse_send;
    tk(1);
    frame(8'h55, 1'b1);
    tk(5);
    chk("clear_busy", busy, 1'b0);
    chk("clear_tx", tx, 1'b1);
    tk(20);
    chk("clear_line_quiet", tx, 1'b1);
    chk("clear_busy_later", busy, 1'b0);
    chk("clear_count_later", cnt, 6'd0);
    // fill past capacity, then drain 32 frames plus CR
    for (int i = 0; i < 32; i++) push_byte(8'(i));
    chk("fill_full", full, 1'b1);
    chk("fill_count", cnt, 6'd32);
    chk("fill_no_ovf", ovf, 1'b0);
    push_byte(8'h20);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_count", cnt, 6'd32);
    chk("ovf_empty", empty, 1'b0);
    pulse_send;
    tk(1);
    chk("drain_first_count", cnt, 6'd31);
    for (int i = 0; i < 32; i++) begin
      frame(8'(i), 1'b0);
      tk(6);
    end
    frame(8'h0D, 1'b0);
    tk(5);
    chk("full_drain_busy", busy, 1'b0);
    chk("full_drain_empty", empty, 1'b1);
    chk("ovf_sticky", ovf, 1'b1);
    // asynchronous reset in the middle of a frame
    push_byte(8'h12);
    push_byte(8'h34);
    pulse_send;
    tk(1);
    chk("pre_rst_tx", tx, 1'b0);
    chk("pre_rst_count", cnt, 6'd1);
    tk(3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1'b1);
    chk("arst_count", cnt, 6'd0);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_busy", busy, 1'b0);
    tk(2);
    chk("arst_hold_tx", tx, 1'b1);
    rst_n = 1'b1;
    tk(2);
    // no CR variant: send on an empty FIFO does nothing
    send2 = 1'b1;
    tk(1);
    send2 = 1'b0;
    chk("nocr_busy0", busy2, 1'b0);
    tk(1);
    chk("nocr_tx1", tx2, 1'b1);
    tk(10);
    chk("nocr_tx2", tx2, 1'b1);
    chk("nocr_busy2", busy2, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
